// File: rtl/spi_gen_pkg.sv
// ----------------------------------------------------------------------------
// spi_gen_pkg : shared state encodings, SPI mode constants and width helpers
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package spi_gen_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEAD  = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_TRAIL = 3'd3;
  localparam logic [2:0] ST_GAP   = 3'd4;

  // {cpol, cpha}
  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  function automatic int spi_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Width needed to count SCK toggles 0 .. 2*dw-1 within one word
  function automatic int edge_cnt_w(input int dw);
    return spi_clog2(2 * dw);
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_tx_fifo.sv
// ----------------------------------------------------------------------------
// spi_tx_fifo : DW x DEPTH transmit FIFO, extra-bit pointers for full/empty
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_tx_fifo
  import spi_gen_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          resetb,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int         AW      = spi_clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          wr_en;
  logic          rd_en;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // A full FIFO refuses a push even when a pop happens in the same cycle
    wr_en    = push && !full;
    rd_en    = pop && !empty;
    wr_ptr_d = wr_en ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = rd_en ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    rdata    = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

`default_nettype wire

// File: rtl/spi_master_gen.sv
// ----------------------------------------------------------------------------
// spi_master_gen : SPI master with configurable width, mode, order and divider
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_master_gen
  import spi_gen_pkg::*;
#(
  parameter int DW    = 8,
  parameter int NCS   = 2,
  parameter int DIVW  = 8,
  parameter int DEPTH = 4,
  localparam int CSW  = (NCS > 1) ? spi_clog2(NCS) : 1
) (
  input  logic            clk,
  input  logic            resetb,
  input  logic [DW-1:0]   tx_data,
  input  logic            tx_valid,
  output logic            tx_ready,
  output logic [DW-1:0]   rx_data,
  output logic            rx_valid,
  input  logic            cpol,
  input  logic            cpha,
  input  logic            lsb_first,
  input  logic [DIVW-1:0] div,
  input  logic [CSW-1:0]  cs_sel,
  input  logic            cs_hold,
  output logic            sck,
  output logic            mosi,
  input  logic            miso,
  output logic [NCS-1:0]  csn,
  output logic            busy
);

  localparam int            EW        = edge_cnt_w(DW);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DW - 1);
  localparam logic [EW-1:0] EDGE_ONE  = EW'(1);
  localparam logic [DIVW-1:0] DIV_ONE = DIVW'(1);

  logic [2:0]      state_q, state_d;
  logic [DIVW-1:0] div_cnt_q, div_cnt_d;
  logic [EW-1:0]   edge_q, edge_d;
  logic [DIVW-1:0] div_cfg_q, div_cfg_d;
  logic            cpha_cfg_q, cpha_cfg_d;
  logic            lsb_cfg_q, lsb_cfg_d;
  logic [DW-1:0]   tx_sh_q, tx_sh_d;
  logic [DW-1:0]   rx_sh_q, rx_sh_d;
  logic            sck_q, sck_d;
  logic            mosi_q, mosi_d;
  logic [NCS-1:0]  csn_q, csn_d;
  logic            chain_q, chain_d;
  logic            done_q, done_d;
  logic            rx_valid_q, rx_valid_d;
  logic [DW-1:0]   rx_data_q, rx_data_d;

  logic            fifo_pop;
  logic            fifo_full;
  logic            fifo_empty;
  logic [DW-1:0]   fifo_rdata;
  logic            tick;
  logic            k_odd;
  logic            last_edge;
  logic [DW-1:0]   tx_shifted;

  function automatic logic first_bit(input logic [DW-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DW-1];
  endfunction

  function automatic logic [DW-1:0] shift_out(input logic [DW-1:0] w, input logic lsb);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  function automatic logic [DW-1:0] shift_in(input logic [DW-1:0] w, input logic lsb,
                                             input logic b);
    return lsb ? {b, w[DW-1:1]} : {w[DW-2:0], b};
  endfunction

  // Out-of-range selects leave every chip select released
  function automatic logic [NCS-1:0] cs_decode(input logic [CSW-1:0] sel);
    logic [NCS-1:0] r;
    r = '1;
    for (int i = 0; i < NCS; i++) begin
      if (int'(sel) == i) r[i] = 1'b0;
    end
    return r;
  endfunction

  spi_tx_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetb (resetb),
    .push   (tx_valid),
    .wdata  (tx_data),
    .pop    (fifo_pop),
    .rdata  (fifo_rdata),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign tick       = (div_cnt_q == div_cfg_q);
  assign k_odd      = ~edge_q[0];
  assign last_edge  = (edge_q == LAST_EDGE);
  assign tx_shifted = shift_out(tx_sh_q, lsb_cfg_q);

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    edge_d     = edge_q;
    div_cfg_d  = div_cfg_q;
    cpha_cfg_d = cpha_cfg_q;
    lsb_cfg_d  = lsb_cfg_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    csn_d      = csn_q;
    chain_d    = chain_q;
    done_d     = 1'b0;
    fifo_pop   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        sck_d     = cpol;
        div_cnt_d = '0;
        if (!fifo_empty) fifo_pop = 1'b1;
      end
      ST_LEAD, ST_XFER: begin
        if (!tick) begin
          div_cnt_d = div_cnt_q + DIV_ONE;
        end else begin
          // Toggle number k = edge_q + 1
          div_cnt_d = '0;
          sck_d     = ~sck_q;
          state_d   = ST_XFER;
          if (cpha_cfg_q ? !k_odd : k_odd)
            rx_sh_d = shift_in(rx_sh_q, lsb_cfg_q, miso);
          if (cpha_cfg_q && k_odd) begin
            mosi_d  = first_bit(tx_sh_q, lsb_cfg_q);
            tx_sh_d = tx_shifted;
          end else if (!cpha_cfg_q && !k_odd && !last_edge) begin
            mosi_d  = first_bit(tx_shifted, lsb_cfg_q);
            tx_sh_d = tx_shifted;
          end
          if (last_edge) begin
            state_d = ST_TRAIL;
            edge_d  = '0;
            done_d  = 1'b1;
            chain_d = cs_hold && !fifo_empty;
          end else begin
            edge_d  = edge_q + EDGE_ONE;
          end
        end
      end
      ST_TRAIL: begin
        if (!tick) begin
          div_cnt_d = div_cnt_q + DIV_ONE;
        end else begin
          div_cnt_d = '0;
          if (chain_q && !fifo_empty) begin
            fifo_pop = 1'b1;
          end else begin
            csn_d   = '1;
            state_d = ST_GAP;
          end
        end
      end
      ST_GAP: begin
        if (!tick) begin
          div_cnt_d = div_cnt_q + DIV_ONE;
        end else begin
          div_cnt_d = '0;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Word start: latch configuration and open the half-period before toggle 1
    if (fifo_pop) begin
      state_d    = ST_LEAD;
      div_cnt_d  = '0;
      edge_d     = '0;
      chain_d    = 1'b0;
      div_cfg_d  = div;
      cpha_cfg_d = cpha;
      lsb_cfg_d  = lsb_first;
      tx_sh_d    = fifo_rdata;
      csn_d      = cs_decode(cs_sel);
      sck_d      = cpol;
      if (!cpha) mosi_d = first_bit(fifo_rdata, lsb_first);
    end

    rx_valid_d = done_q;
    rx_data_d  = done_q ? rx_sh_q : rx_data_q;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q    <= ST_IDLE;
      div_cnt_q  <= '0;
      edge_q     <= '0;
      div_cfg_q  <= '0;
      cpha_cfg_q <= 1'b0;
      lsb_cfg_q  <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
      csn_q      <= '1;
      chain_q    <= 1'b0;
      done_q     <= 1'b0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_q     <= edge_d;
      div_cfg_q  <= div_cfg_d;
      cpha_cfg_q <= cpha_cfg_d;
      lsb_cfg_q  <= lsb_cfg_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
      csn_q      <= csn_d;
      chain_q    <= chain_d;
      done_q     <= done_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
    end
  end

  assign tx_ready = !fifo_full;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign sck      = sck_q;
  assign mosi     = mosi_q;
  assign csn      = csn_q;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_gen.sv
// ----------------------------------------------------------------------------
// tb_spi_master_gen : directed self-checking bench for spi_master_gen
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_spi_master_gen;

  localparam int DW    = 8;
  localparam int NCS   = 3;   // three selects so that cs_sel=3 is representable and out of range
  localparam int DIVW  = 8;
  localparam int DEPTH = 4;

  logic           clk = 1'b0;
  logic           resetb;
  logic [DW-1:0]  tx_data;
  logic           tx_valid;
  logic           tx_ready;
  logic [DW-1:0]  rx_data;
  logic           rx_valid;
  logic           cpol;
  logic           cpha;
  logic           lsb_first;
  logic [DIVW-1:0] div;
  logic [1:0]     cs_sel;
  logic           cs_hold;
  logic           sck;
  logic           mosi;
  logic           miso;
  logic [NCS-1:0] csn;
  logic           busy;

  int checks = 0;
  int errors = 0;

  spi_master_gen #(
    .DW    (DW),
    .NCS   (NCS),
    .DIVW  (DIVW),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .resetb    (resetb),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .cpol      (cpol),
    .cpha      (cpha),
    .lsb_first (lsb_first),
    .div       (div),
    .cs_sel    (cs_sel),
    .cs_hold   (cs_hold),
    .sck       (sck),
    .mosi      (mosi),
    .miso      (miso),
    .csn       (csn),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [DW-1:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 3000) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] pat;
    int nrx, rel, relc, early, other, first_rx, c4, tog, bad, seen_rx, seen_busy;
    int rxc [3];
    logic prev;

    resetb = 1'b0; tx_valid = 1'b0; tx_data = '0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; div = '0;
    cs_sel = 2'd0; cs_hold = 1'b0; miso = 1'b0;
    tick(3);

    // Reset state
    chk("rst_sck",      32'(sck),      32'd0);
    chk("rst_mosi",     32'(mosi),     32'd0);
    chk("rst_csn",      32'(csn),      32'h7);
    chk("rst_rx_valid", 32'(rx_valid), 32'd0);
    chk("rst_rx_data",  32'(rx_data),  32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    resetb = 1'b1;
    tick(1);
    chk("rst_tx_ready", 32'(tx_ready), 32'd1);

    // Mode 0, div 0, MSB first, 0xA5 out, miso 0xA5 in
    d = 8'hA5; pat = 8'hA5;
    push1(d);
    tick(1);
    chk("t1_csn_t0", 32'(csn), 32'h6);
    for (int c = 0; c <= 18; c++) begin
      if (c > 0) tick(1);
      if ((c % 2) == 0 && c < 16) begin
        miso = pat[7 - c / 2];
        chk("t1_mosi", 32'(mosi), 32'(d[7 - c / 2]));
      end
      if (c <= 16) chk("t1_sck", 32'(sck), 32'(c % 2));
      if (c == 16) begin
        chk("t1_rxv_early", 32'(rx_valid), 32'd0);
        chk("t1_csn_held",  32'(csn),      32'h6);
      end
      if (c == 17) begin
        chk("t1_rx_valid", 32'(rx_valid), 32'd1);
        chk("t1_rx_data",  32'(rx_data),  32'hA5);
        chk("t1_csn_rel",  32'(csn),      32'h7);
        chk("t1_busy_gap", 32'(busy),     32'd1);
      end
      if (c == 18) begin
        chk("t1_rxv_pulse", 32'(rx_valid), 32'd0);
        chk("t1_busy_done", 32'(busy),     32'd0);
      end
    end
    wait_idle("t1_idle");

    // Mode 3, div 3, LSB first, 0x01 out, miso 0x3C in
    cpol = 1'b1; cpha = 1'b1; lsb_first = 1'b1; div = 8'd3;
    pat = 8'h3C;
    tick(1);
    chk("t2_idle_sck", 32'(sck), 32'd1);
    push1(8'h01);
    tick(1);
    chk("t2_csn_t0", 32'(csn), 32'h6);
    for (int c = 0; c <= 70; c++) begin
      if (c > 0) tick(1);
      if (c <= 64) chk("t2_sck", 32'(sck), 32'(1 ^ ((c / 4) % 2)));
      if ((c % 8) == 4 && c < 64) miso = pat[(c - 4) / 8];
      if (c == 4)  chk("t2_mosi_b0", 32'(mosi), 32'd1);
      if (c == 12) chk("t2_mosi_b1", 32'(mosi), 32'd0);
      if (c == 64) chk("t2_rxv_early", 32'(rx_valid), 32'd0);
      if (c == 65) begin
        chk("t2_rx_valid", 32'(rx_valid), 32'd1);
        chk("t2_rx_data",  32'(rx_data),  32'h3C);
      end
      if (c == 67) chk("t2_csn_held", 32'(csn), 32'h6);
      if (c == 68) chk("t2_csn_rel",  32'(csn), 32'h7);
      if (c == 70) chk("t2_sck_idle", 32'(sck), 32'd1);
    end
    wait_idle("t2_idle");

    // cs_hold chaining of three words on csn[1], div 1
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; div = 8'd1;
    cs_sel = 2'd1; cs_hold = 1'b1; miso = 1'b1;
    tick(1);
    tx_valid = 1'b1; tx_data = 8'h11;
    tick(1);
    tx_data = 8'h22;
    tick(1);
    chk("t3_csn_t0", 32'(csn), 32'h5);
    tx_data = 8'h33;
    tick(1);
    tx_valid = 1'b0;
    nrx = 0; rel = 0; relc = -1; early = 0; other = 0; prev = 1'b0;
    for (int c = 1; c <= 130; c++) begin
      if (c > 1) tick(1);
      if (rx_valid) begin
        if (nrx < 3) rxc[nrx] = c;
        nrx++;
      end
      if (csn[1] && !prev) begin
        rel++;
        relc = c;
      end
      prev = csn[1];
      if (c < 102 && csn[1]) early++;
      if (!csn[0] || !csn[2]) other++;
    end
    chk("t3_rx_count",  32'(nrx),   32'd3);
    chk("t3_rx0_cycle", 32'(rxc[0]), 32'd33);
    chk("t3_rx1_cycle", 32'(rxc[1]), 32'd67);
    chk("t3_rx2_cycle", 32'(rxc[2]), 32'd101);
    chk("t3_releases",  32'(rel),   32'd1);
    chk("t3_rel_cycle", 32'(relc),  32'd102);
    chk("t3_cs_gaps",   32'(early), 32'd0);
    chk("t3_other_cs",  32'(other), 32'd0);
    chk("t3_rx_data",   32'(rx_data), 32'hFF);
    wait_idle("t3_idle");

    // FIFO fill during a long word: four accepted, fifth refused
    cs_hold = 1'b0; cs_sel = 2'd0; div = 8'd7; miso = 1'b0;
    push1(8'h81);
    tick(1);
    chk("t4_csn_t0", 32'(csn), 32'h6);
    div = 8'd0;
    for (int i = 0; i < 5; i++) begin
      tx_data  = 8'(8'h10 + i);
      tx_valid = 1'b1;
      chk("t4_ready", 32'(tx_ready), 32'(i < 4));
      tick(1);
    end
    tx_valid = 1'b0;
    chk("t4_ready_full", 32'(tx_ready), 32'd0);
    c4 = 5; nrx = 0; first_rx = -1;
    while (busy && c4 < 3000) begin
      tick(1);
      c4++;
      if (rx_valid) begin
        nrx++;
        if (first_rx < 0) first_rx = c4;
      end
    end
    chk("t4_transfers",   32'(nrx),      32'd5);
    chk("t4_first_rx",    32'(first_rx), 32'd129);
    chk("t4_idle",        32'(busy),     32'd0);
    chk("t4_ready_after", 32'(tx_ready), 32'd1);

    // Asynchronous reset at toggle 7 with a word still queued
    div = 8'd1;
    tx_valid = 1'b1; tx_data = 8'hC3;
    tick(1);
    tx_data = 8'h3C;
    tick(1);
    tx_valid = 1'b0;
    chk("t5_csn_t0", 32'(csn), 32'h6);
    tick(14);
    chk("t5_sck_t7",  32'(sck),  32'd1);
    chk("t5_busy_t7", 32'(busy), 32'd1);
    resetb = 1'b0;
    #1;
    chk("t5_sck",      32'(sck),      32'd0);
    chk("t5_mosi",     32'(mosi),     32'd0);
    chk("t5_csn",      32'(csn),      32'h7);
    chk("t5_busy",     32'(busy),     32'd0);
    chk("t5_tx_ready", 32'(tx_ready), 32'd1);
    chk("t5_rx_valid", 32'(rx_valid), 32'd0);
    tick(2);
    resetb = 1'b1;
    seen_rx = 0; seen_busy = 0;
    for (int c = 0; c < 40; c++) begin
      tick(1);
      if (rx_valid) seen_rx++;
      if (busy || csn != 3'b111) seen_busy++;
    end
    chk("t5_no_rx",   32'(seen_rx),   32'd0);
    chk("t5_no_busy", 32'(seen_busy), 32'd0);

    // Out-of-range select: full timing, no chip select asserted
    div = 8'd0; cs_sel = 2'd3;
    d = 8'h5A; pat = 8'h96;
    push1(d);
    tick(1);
    bad = 0; tog = 0; prev = sck;
    for (int c = 0; c <= 18; c++) begin
      if (c > 0) tick(1);
      if (csn != 3'b111) bad++;
      if (sck != prev) tog++;
      prev = sck;
      if ((c % 2) == 0 && c < 16) begin
        miso = pat[7 - c / 2];
        chk("t6_mosi", 32'(mosi), 32'(d[7 - c / 2]));
      end
      if (c == 17) begin
        chk("t6_rx_valid", 32'(rx_valid), 32'd1);
        chk("t6_rx_data",  32'(rx_data),  32'h96);
      end
    end
    chk("t6_csn_high", 32'(bad), 32'd0);
    chk("t6_toggles",  32'(tog), 32'd16);
    wait_idle("t6_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
